// File: rtl/keypad_entry_if.sv
// Keypad pin and entry-result bundle shared by keypad_entry and its environment.
// Value_valid is a one-cycle strobe with no back-pressure: a consumer must capture Value_out in that cycle.
interface keypad_entry_if;
    logic [3:0] Col_in;
    logic [3:0] Row_out;
    logic [7:0] Acc_out;
    logic [1:0] Digit_count;
    logic [7:0] Value_out;
    logic       Value_valid;
    logic       Entry_error;
    logic [1:0] dbg_state;

    modport master (
        output Col_in,
        input  Row_out, Acc_out, Digit_count, Value_out, Value_valid, Entry_error, dbg_state
    );

    modport slave (
        input  Col_in,
        output Row_out, Acc_out, Digit_count, Value_out, Value_valid, Entry_error, dbg_state
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with press/release debounce and a 3-digit decimal entry (0-255).
// Decoded keys update the entry one cycle after the scanner accepts them.
module keypad_entry #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic          Clk,
    input  logic          Rst,
    keypad_entry_if.slave kp
);
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_DIGIT = 2'd0,
        K_STAR  = 2'd1,
        K_HASH  = 2'd2,
        K_NONE  = 2'd3
    } kind_t;

    state_t          state_q;
    logic [3:0]      col_s1_q;
    logic [3:0]      col_s2_q;
    logic [1:0]      row_q;
    logic [3:0]      row_out_q;
    logic [SW-1:0]   scan_cnt_q;
    logic [DW-1:0]   db_cnt_q;
    logic [1:0]      col_q;
    logic            key_accept_q;
    logic [3:0]      key_q;

    logic [7:0]      acc_q, acc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [7:0]      value_q, value_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    kind_t           key_kind;
    logic [3:0]      key_digit;
    logic [9:0]      prod;

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    // Priority to column 0 so simultaneous presses on one row resolve deterministically.
    function automatic logic [1:0] first_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= SCAN;
            col_s1_q     <= 4'b1111;
            col_s2_q     <= 4'b1111;
            row_q        <= 2'd0;
            row_out_q    <= 4'b1110;
            scan_cnt_q   <= '0;
            db_cnt_q     <= '0;
            col_q        <= 2'd0;
            key_accept_q <= 1'b0;
            key_q        <= 4'd0;
        end else begin
            col_s1_q     <= kp.Col_in;
            col_s2_q     <= col_s1_q;
            key_accept_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (scan_cnt_q == SCAN_LAST) begin
                        scan_cnt_q <= '0;
                        if (col_s2_q != 4'b1111) begin
                            col_q    <= first_low(col_s2_q);
                            db_cnt_q <= '0;
                            state_q  <= PRESS_DB;
                        end else begin
                            row_q     <= row_q + 2'd1;
                            row_out_q <= row_drive(row_q + 2'd1);
                        end
                    end else begin
                        scan_cnt_q <= scan_cnt_q + 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (col_s2_q[col_q]) begin
                        state_q    <= SCAN;
                        scan_cnt_q <= '0;
                        db_cnt_q   <= '0;
                        row_q      <= row_q + 2'd1;
                        row_out_q  <= row_drive(row_q + 2'd1);
                    end else if (db_cnt_q == DB_LAST) begin
                        key_accept_q <= 1'b1;
                        key_q        <= {row_q, col_q};
                        db_cnt_q     <= '0;
                        state_q      <= HELD;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (col_s2_q == 4'b1111) begin
                        db_cnt_q <= '0;
                        state_q  <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (col_s2_q != 4'b1111) begin
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= SCAN;
                        scan_cnt_q <= '0;
                        db_cnt_q   <= '0;
                        row_q      <= row_q + 2'd1;
                        row_out_q  <= row_drive(row_q + 2'd1);
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    // Key index is {row, column}; layout 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
    always_comb begin
        key_kind  = K_NONE;
        key_digit = 4'd0;
        case (key_q)
            4'd0:    begin key_kind = K_DIGIT; key_digit = 4'd1; end
            4'd1:    begin key_kind = K_DIGIT; key_digit = 4'd2; end
            4'd2:    begin key_kind = K_DIGIT; key_digit = 4'd3; end
            4'd4:    begin key_kind = K_DIGIT; key_digit = 4'd4; end
            4'd5:    begin key_kind = K_DIGIT; key_digit = 4'd5; end
            4'd6:    begin key_kind = K_DIGIT; key_digit = 4'd6; end
            4'd8:    begin key_kind = K_DIGIT; key_digit = 4'd7; end
            4'd9:    begin key_kind = K_DIGIT; key_digit = 4'd8; end
            4'd10:   begin key_kind = K_DIGIT; key_digit = 4'd9; end
            4'd12:   key_kind = K_STAR;
            4'd13:   begin key_kind = K_DIGIT; key_digit = 4'd0; end
            4'd14:   key_kind = K_HASH;
            default: key_kind = K_NONE;
        endcase
    end

    // With at most two digits held the accumulator is <= 99, so 10 bits never wrap.
    assign prod = 10'(acc_q) * 10'd10 + 10'(key_digit);

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (key_accept_q) begin
            case (key_kind)
                K_DIGIT: begin
                    if (cnt_q == 2'd3 || prod > 10'd255) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d = prod[7:0];
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                K_HASH: begin
                    if (cnt_q != 2'd0) begin
                        value_d = acc_q;
                        valid_d = 1'b1;
                        acc_d   = 8'd0;
                        cnt_d   = 2'd0;
                        err_d   = 1'b0;
                    end
                end
                K_STAR: begin
                    acc_d = 8'd0;
                    cnt_d = 2'd0;
                    err_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_q   <= 8'd0;
            cnt_q   <= 2'd0;
            value_q <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign kp.Row_out     = row_out_q;
    assign kp.Acc_out     = acc_q;
    assign kp.Digit_count = cnt_q;
    assign kp.Value_out   = value_q;
    assign kp.Value_valid = valid_q;
    assign kp.Entry_error = err_q;
    assign kp.dbg_state   = state_q;
endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each keypad row is driven before advancing (min 2).
REQ-002 Parameter DEBOUNCE_CNT, default 20000: consecutive stable cycles required for press and release qualification (min 2).
REQ-003 Port Clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port Rst  input  1: synchronous, active-high reset.
REQ-005 Port Col_in  input  4: keypad columns, active-low, externally pulled up; synchronised internally by a 2-flop synchroniser.
REQ-006 Port Row_out  output  4: keypad row drive, active-low, exactly one bit low at all times.
REQ-007 Port Acc_out  output  8: live accumulated entry value, for the display multiplexer.
REQ-008 Port Digit_count  output  2: number of digits accepted into the current entry (0-3).
REQ-009 Port Value_out  output  8: last committed value, held until the next commit.
REQ-010 Port Value_valid  output  1: one-cycle pulse in the cycle Value_out updates.
REQ-011 Port Entry_error  output  1: sticky flag, set when a digit is rejected.

Function
REQ-012 Key map, row r and column c (index 0 = bit 0), SHALL be: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
REQ-013 The FSM SHALL have states SCAN, PRESS_DB, HELD and RELEASE_DB.
REQ-014 SCAN: Row_out SHALL drive row k low for SCAN_DIV cycles, then advance to k+1 (wrapping 3 to 0).
  - Synchronised columns are sampled only in the last cycle of the dwell.
  - If any column is low in that sample: latch row and lowest-index low column, hold row, go to PRESS_DB.
REQ-015 PRESS_DB: row SHALL stay held while the latched column is checked for DEBOUNCE_CNT consecutive cycles.
  - Latched column high in any cycle: return to SCAN and advance the row.
  - Count reached: accept the key exactly once, then go to HELD.
REQ-016 HELD: row stays held; all columns high SHALL move the FSM to RELEASE_DB.
REQ-017 RELEASE_DB: all columns high for DEBOUNCE_CNT consecutive cycles SHALL return the FSM to SCAN with the row advanced.
  - Any column low restarts the count.
  - No key is accepted in HELD or RELEASE_DB.
REQ-018 Accepted digit d, Digit_count = 3: reject, set Entry_error, accumulator unchanged.
REQ-019 Accepted digit d, Digit_count < 3: compute Acc*10+d at 10-bit width.
  - Result > 255: reject, set Entry_error, accumulator and count unchanged.
  - Otherwise: Acc_out = result, Digit_count increments.
REQ-020 Accepted '#' with Digit_count > 0: the next cycle SHALL have Value_out = Acc_out, Value_valid = 1 for exactly one cycle, Acc_out = 0, Digit_count = 0, Entry_error = 0.
REQ-021 Accepted '#' with Digit_count = 0: no effect, no pulse.
REQ-022 Accepted '*': Acc_out = 0, Digit_count = 0, Entry_error = 0; Value_out unchanged.
REQ-023 Accepted A, B, C or D: no effect.
REQ-024 Accumulator, Value_out and Entry_error updates SHALL occur in the cycle after key acceptance (latency 1).
REQ-025 Multiple keys pressed: only the key latched per REQ-014 is processed; others are ignored until full release.

Reset
REQ-026 While Rst = 1 at a clock edge, the block SHALL set:
  - FSM = SCAN, Row_out = 4'b1110, scan and debounce counters = 0, synchroniser flops = 4'b1111;
  - Acc_out = 0, Digit_count = 0, Value_out = 0, Value_valid = 0, Entry_error = 0.
REQ-027 Reset asserted in any state, including mid-debounce or mid-entry, SHALL abort the operation with no key accepted and no Value_valid pulse.

Verification (SCAN_DIV = 4, DEBOUNCE_CNT = 8)
REQ-028 Press/release '1', '2', '3', '#' -> Value_out = 123, one Value_valid pulse, then Acc_out = 0, Digit_count = 0.
REQ-029 Press '2', '5', '6' -> third digit rejected (256 > 255), Entry_error = 1, Acc_out = 25; then '#' -> Value_out = 25, Entry_error = 0.
REQ-030 Column low for 5 cycles during PRESS_DB, then bounce high -> no key accepted, Acc_out unchanged, scan resumes on the next row.
REQ-031 Hold '7' for 200 cycles, with one 3-cycle high glitch in HELD -> exactly one digit accepted, Acc_out = 7.
REQ-032 Enter '4', '2', then '*', then '#' -> Acc_out = 0, Digit_count = 0, no Value_valid pulse, Value_out unchanged.
REQ-033 Assert Rst during PRESS_DB with digits pending -> next cycle Row_out = 4'b1110 and all outputs at reset values; key not accepted after Rst release unless re-pressed.
